// File: rtl/pc_branch_update.sv
// pc_branch_update: program-counter stage fed by the offset sign-extend/shift unit.
// Holds PC and computes PC+4 and the branch target. A taken transfer redirects
// fetch and is followed by exactly one squashed (FLUSH) slot. The PC freezes
// while memory asserts busywait, and a decision made in the stall-entry cycle
// is latched so that it is not lost.
// Optional build macro: PC_BRANCH_STATS_EN adds a saturating taken-transfer
// counter on o_taken_count (COUNT_W bits wide).
//
// state     | meaning
// ST_RUN    | normal fetch; PC advances to next on each non-stalled edge
// ST_WAIT   | memory stall; captured next PC held in r_pend until busywait drops
// ST_SQUASH | slot after a redirect; fetched instruction is discarded, FLUSH high
module pc_branch_update #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_busywait,
  input  logic                i_jump,
  input  logic                i_beq,
  input  logic                i_bne,
  input  logic                i_zero,
  input  logic [31:0]         i_offset_ext,
  output logic [31:0]         o_pc,
  output logic [31:0]         o_pc_plus4,
`ifdef PC_BRANCH_STATS_EN
  output logic                o_flush,
  output logic [COUNT_W-1:0]  o_taken_count
`else
  output logic                o_flush
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_pend;
  logic [31:0] w_pend_nxt;
  logic        r_pend_taken;
  logic        w_pend_taken_nxt;
  logic        r_flush;

  logic        w_taken;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_next;

  // Datapath: all arithmetic is mod 2^32, wrap-around is intentional.
  assign w_taken    = i_jump | (i_beq & i_zero) | (i_bne & ~i_zero);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = w_pc_plus4 + i_offset_ext;
  assign w_next     = w_taken ? w_target : w_pc_plus4;

  // State, PC, pending-target and FLUSH registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_pend       <= 32'd0;
      r_pend_taken <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_taken <= w_pend_taken_nxt;
      r_flush      <= (w_state_nxt == ST_SQUASH);
    end
  end

  // Next-state and next-PC selection; everything holds unless a branch below moves it.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_nxt       = r_pend;
    w_pend_taken_nxt = r_pend_taken;
    unique case (r_state)
      ST_RUN: begin
        if (i_busywait) begin
          w_pend_nxt       = w_next;
          w_pend_taken_nxt = w_taken;
          w_state_nxt      = ST_WAIT;
        end else begin
          w_pc_nxt    = w_next;
          w_state_nxt = w_taken ? ST_SQUASH : ST_RUN;
        end
      end
      ST_WAIT: begin
        if (!i_busywait) begin
          w_pc_nxt    = r_pend;
          w_state_nxt = r_pend_taken ? ST_SQUASH : ST_RUN;
        end
      end
      ST_SQUASH: begin
        // The squashed instruction's controls never redirect.
        if (!i_busywait) begin
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;
  assign o_flush    = r_flush;

`ifdef PC_BRANCH_STATS_EN
  logic [COUNT_W-1:0] r_taken_count;
  logic               w_enter_squash;

  assign w_enter_squash = (w_state_nxt == ST_SQUASH) && (r_state != ST_SQUASH);

  // Saturating count of committed taken transfers (entries into SQUASH).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_taken_count <= '0;
    end else if (w_enter_squash && (r_taken_count != {COUNT_W{1'b1}})) begin
      r_taken_count <= r_taken_count + 1'b1;
    end
  end

  assign o_taken_count = r_taken_count;
`endif

endmodule
